key_debounce: RTL and testbench



---
 rtl/key_debounce_if.sv | 17 +
 rtl/key_debounce.sv | 121 ++++++++++++
 tb/tb_key_debounce.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Key debounce port bundle: raw key in, debounced level and busy flag out.
// Optional glitch counter ports appear when KEY_DEBOUNCE_GLITCH_CNT_EN is defined.
interface key_debounce_if;
    logic key_in;
    logic key_stable;
    logic busy;
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    logic       glitch_clr;
    logic [7:0] glitch_cnt;

    modport master (output key_in, output glitch_clr, input key_stable, input busy, input glitch_cnt);
    modport slave  (input key_in, input glitch_clr, output key_stable, output busy, output glitch_cnt);
`else
    modport master (output key_in, input key_stable, input busy);
    modport slave  (input key_in, output key_stable, output busy);
`endif
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus four-state debounce FSM producing a clean registered key level.
// Define KEY_DEBOUNCE_GLITCH_CNT_EN to add a saturating count of aborted qualifications.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20,
    parameter logic        IDLE_LEVEL      = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    key_debounce_if.slave kd
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        RISE_CHK  = 2'd1,
        STABLE_HI = 2'd2,
        FALL_CHK  = 2'd3
    } state_t;

    localparam state_t          RST_STATE = IDLE_LEVEL ? STABLE_HI : STABLE_LO;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic             key_sync;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             stable;
    logic             stable_next;
    logic             busy_q;

    // key_in is asynchronous: only sync2 is allowed to reach the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= kd.key_in;
            sync2 <= sync1;
        end
    end

    assign key_sync = sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RST_STATE;
            cnt    <= '0;
            stable <= IDLE_LEVEL;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            stable <= stable_next;
            busy_q <= (state_next == RISE_CHK) || (state_next == FALL_CHK);
        end
    end

    // Any sample back at the old level drops to the stable state with cnt cleared
    always_comb begin
        state_next  = state;
        cnt_next    = '0;
        stable_next = stable;
        case (state)
            STABLE_LO: begin
                if (key_sync) state_next = RISE_CHK;
            end
            RISE_CHK: begin
                if (!key_sync) begin
                    state_next = STABLE_LO;
                end else if (cnt == CNT_LAST) begin
                    state_next  = STABLE_HI;
                    stable_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!key_sync) state_next = FALL_CHK;
            end
            FALL_CHK: begin
                if (key_sync) begin
                    state_next = STABLE_HI;
                end else if (cnt == CNT_LAST) begin
                    state_next  = STABLE_LO;
                    stable_next = 1'b0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: state_next = RST_STATE;
        endcase
    end

    assign kd.key_stable = stable;
    assign kd.busy       = busy_q;

`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    logic       abort;
    logic [7:0] glitch_q;

    assign abort = ((state == RISE_CHK) && !key_sync) || ((state == FALL_CHK) && key_sync);

    // Clear takes priority over a coincident abort; count saturates at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= 8'd0;
        end else if (kd.glitch_clr) begin
            glitch_q <= 8'd0;
        end else if (abort && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign kd.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: three parameterisations driven together, table vectors, corner sequences, random vs model.
module tb_key_debounce;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    key_debounce_if ifa ();
    key_debounce_if ifb ();
    key_debounce_if ifc ();

    key_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .IDLE_LEVEL(1'b0)) u_a (.clk(clk), .rst_n(rst_n), .kd(ifa.slave));
    key_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .IDLE_LEVEL(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .kd(ifb.slave));
    key_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(1), .IDLE_LEVEL(1'b0)) u_c (.clk(clk), .rst_n(rst_n), .kd(ifc.slave));

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: run length of consecutive synchronised samples opposite the accepted level
    int d_cfg[3]   = '{4, 4, 1};
    bit idle_cfg[3] = '{1'b0, 1'b1, 1'b0};
    bit h0[3];
    bit h1[3];
    bit m_stable[3];
    int m_run[3];
    int m_glitch[3];

    typedef struct {
        bit k;
        bit ks;
        bit busy;
    } vec_t;
    vec_t tbl[28];

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            h0[i] = idle_cfg[i];
            h1[i] = idle_cfg[i];
            m_stable[i] = idle_cfg[i];
            m_run[i] = 0;
            m_glitch[i] = 0;
        end
    endfunction

    function automatic void model_edge(input bit k, input bit clr);
        for (int i = 0; i < 3; i++) begin
            bit s;
            bit ab;
            s = h0[i];
            h0[i] = h1[i];
            h1[i] = k;
            ab = 1'b0;
            if (s != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == d_cfg[i] + 1) begin
                    m_stable[i] = s;
                    m_run[i] = 0;
                end
            end else begin
                if (m_run[i] > 0) ab = 1'b1;
                m_run[i] = 0;
            end
            if (clr) m_glitch[i] = 0;
            else if (ab && m_glitch[i] < 255) m_glitch[i]++;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, " a.key_stable"}, int'(ifa.key_stable), int'(m_stable[0]));
        check({tag, " a.busy"}, int'(ifa.busy), int'(m_run[0] > 0));
        check({tag, " b.key_stable"}, int'(ifb.key_stable), int'(m_stable[1]));
        check({tag, " b.busy"}, int'(ifb.busy), int'(m_run[1] > 0));
        check({tag, " c.key_stable"}, int'(ifc.key_stable), int'(m_stable[2]));
        check({tag, " c.busy"}, int'(ifc.busy), int'(m_run[2] > 0));
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        check({tag, " a.glitch_cnt"}, int'(ifa.glitch_cnt), m_glitch[0]);
        check({tag, " b.glitch_cnt"}, int'(ifb.glitch_cnt), m_glitch[1]);
        check({tag, " c.glitch_cnt"}, int'(ifc.glitch_cnt), m_glitch[2]);
`endif
    endtask

    task automatic drive(input bit k, input bit clr);
        ifa.key_in = k;
        ifb.key_in = k;
        ifc.key_in = k;
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        ifa.glitch_clr = clr;
        ifb.glitch_clr = clr;
        ifc.glitch_clr = clr;
`else
        if (clr) begin end
`endif
    endtask

    task automatic step(input bit k, input bit clr, input string tag);
        drive(k, clr);
        @(posedge clk);
        model_edge(k, clr);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            drive(i[0], 1'b0);
            @(posedge clk);
            #1;
            check("reset a.key_stable", int'(ifa.key_stable), 0);
            check("reset a.busy", int'(ifa.busy), 0);
            check("reset b.key_stable", int'(ifb.key_stable), 1);
            check("reset b.busy", int'(ifb.busy), 0);
            check("reset c.key_stable", int'(ifc.key_stable), 0);
        end
        drive(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        bit [0:27] kv;
        bit [0:27] sv;
        bit [0:27] bv;
        bit prev_ks;
        int press_pulses;
        int release_pulses;
        bit lvl;
        int hold;

        kv = 28'b11111111_00000000_1110_11111111;
        sv = 28'b000000_11111111_000000000000_11;
        bv = 28'b00_1111_0000_1111_0000_111_0_1111_00;
        for (int i = 0; i < 28; i++) tbl[i] = '{kv[i], sv[i], bv[i]};

        drive(1'b0, 1'b0);
        #2;
        do_reset(4);

        // Press, release and bounced press on the D=4 instance
        prev_ks = 1'b0;
        press_pulses = 0;
        release_pulses = 0;
        for (int i = 0; i < 28; i++) begin
            step(tbl[i].k, 1'b0, $sformatf("tbl[%0d]", i));
            check($sformatf("tbl[%0d] key_stable", i), int'(ifa.key_stable), int'(tbl[i].ks));
            check($sformatf("tbl[%0d] busy", i), int'(ifa.busy), int'(tbl[i].busy));
            if (ifa.key_stable && !prev_ks) begin
                if (i < 8) press_pulses++;
                else if (i < 16) release_pulses++;
            end
            prev_ks = ifa.key_stable;
        end
        check("edge pulses on press", press_pulses, 1);
        check("edge pulses on release", release_pulses, 0);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        check("bounce glitch_cnt", int'(ifa.glitch_cnt), 1);
`endif

        // D=1: two consecutive samples suffice, one cycle busy
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, $sformatf("d1[%0d]", i));
            check($sformatf("d1[%0d] c.key_stable", i), int'(ifc.key_stable), int'(i >= 3));
            check($sformatf("d1[%0d] c.busy", i), int'(ifc.busy), int'(i == 2));
        end

        // Reset in the middle of a qualification
        do_reset(2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "midq pre");
        check("midq busy before reset", int'(ifa.busy), 1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midq a.key_stable immediate", int'(ifa.key_stable), 0);
        check("midq a.busy immediate", int'(ifa.busy), 0);
        check("midq b.key_stable immediate", int'(ifb.key_stable), 1);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, $sformatf("midq post[%0d]", i));
            check($sformatf("midq post[%0d] a.key_stable", i), int'(ifa.key_stable), int'(i >= 6));
        end

`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        // 260 single-cycle glitches saturate the counter
        do_reset(2);
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 1'b0, "glitch hi");
            step(1'b0, 1'b0, "glitch lo");
        end
        step(1'b0, 1'b0, "glitch settle");
        step(1'b0, 1'b0, "glitch settle");
        check("glitch_cnt saturated", int'(ifa.glitch_cnt), 255);
        // One more glitch with clear on the aborting edge
        step(1'b1, 1'b0, "clr glitch");
        step(1'b0, 1'b0, "clr glitch");
        step(1'b0, 1'b0, "clr glitch");
        step(1'b0, 1'b1, "clr on abort");
        check("glitch_clr wins over abort", int'(ifa.glitch_cnt), 0);
        drive(1'b0, 1'b0);
`endif

        // Random bursty stimulus against the model
        do_reset(2);
        lvl = 1'b0;
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                lvl = 1'($urandom_range(0, 1));
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(1, 4));
            end
            hold--;
            step(lvl, ($urandom_range(0, 63) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
